data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
//   8-bit datapath of the project computer, downstream of the control unit.
//   - Holds IR, MAR, PC, A, B and CCR.
//   - Drives the two internal buses and the ALU.
//   - Exposes the memory address / write-data interface.
//   - Consumes every control-unit output; returns IR and CCR_Result to it.
// PARAMETERS
//   DATA_W   8      width of data, buses, IR, PC, MAR, A, B (CCR fixed at 4)
//   PC_RST   8'h00  PC value after reset (first opcode fetch address)
// PORTS
//   Clk          in   1   rising-edge clock, single clock domain
//   Reset        in   1   synchronous, active-low reset
//   IR_Load      in   1   IR <= Bus2 on next edge
//   MAR_Load     in   1   MAR <= Bus2 on next edge
//   PC_Load      in   1   PC <= Bus2 on next edge
//   PC_Inc       in   1   PC <= PC + 1 on next edge
//   A_Load       in   1   A <= Bus2 on next edge
//   B_Load       in   1   B <= Bus2 on next edge
//   CCR_Load     in   1   CCR <= ALU NZVC on next edge
//   ALU_Sel      in   3   000 ADD, 001 SUB, 010 AND, 011 OR,
//                         100 INC, 101 DEC, 110 XOR, 111 NOT
//   Bus1_Sel     in   2   00 PC, 01 A, 10 B, 11 -> 8'h00
//   Bus2_Sel     in   2   00 ALU_Result, 01 Bus1, 10 from_memory, 11 -> 8'h00
//   from_memory  in   8   read data from the memory system
//   address      out  8   memory address (= MAR register)
//   to_memory    out  8   memory write data (= Bus1, combinational)
//   IR           out  8   instruction register contents
//   CCR_Result   out  4   {N,Z,V,C} register contents
// BEHAVIOUR
//   Reset
//   - Reset=0 at a rising edge clears IR, MAR, A, B and CCR to 0 and sets PC=PC_RST.
//   - Reset overrides every load/inc in that cycle; takes effect mid-instruction.
//   - Outputs follow the registers, so after reset: address=0, IR=0, CCR_Result=0.
//   Buses
//   - Bus1 and Bus2 are purely combinational muxes.
//   - All register updates take effect at the edge: value visible one cycle after the load strobe.
//   Registers
//   - Each register holds its value when its load is low.
//   - Several loads in one cycle are legal; all sample the same Bus2 value.
//   - PC: PC_Load has priority over PC_Inc when both are high.
//   - PC_Inc wraps 8'hFF -> 8'h00 with no flag.
//   ALU (operands X=Bus1, Y=B register)
//   - Result = X+Y, X-Y, X&Y, X|Y, X+1, X-1, X^Y, ~X, truncated to 8 bits.
//   - N = Result[7]; Z = (Result==0).
//   - ADD/INC: C = carry out of bit 7; V = signed overflow (operands same sign, result different).
//   - SUB/DEC: C = borrow (X<Y unsigned for SUB, X==0 for DEC); V = signed overflow of X-Y or X-1.
//   - AND/OR/XOR/NOT: V=0, C=0.
//   - CCR changes only on CCR_Load; ALU flags are not otherwise stored.
//   Memory interface
//   - address is MAR, never Bus2 directly.
//   - A synchronous ROM/RAM returns data on from_memory one cycle after MAR changes.
//   - The control unit's S0->S2 fetch spacing covers that latency.
//   - The datapath adds no extra pipelining.
// STRUCTURE
//   - Shared include cpu_defs.vh (shared with control_unit):
//     ALU_Sel codes, Bus1_Sel/Bus2_Sel codes, CCR bit indices N=3 Z=2 V=1 C=0.
//   - Sub-module alu_8bit: combinational; in X, Y, ALU_Sel; out Result[7:0], NZVC[3:0].
//   - Remaining logic: 2 muxes and 6 registers in data_path.
// TESTING
//   1. Reset=0 for 1 edge while every load is high
//      -> PC=00, IR=MAR=A=B=00, CCR_Result=0000.
//   2. from_memory=8'h86, Bus2_Sel=10, IR_Load=1 for one edge
//      -> IR=86 next cycle; other registers unchanged.
//   3. A=7F, B=01, Bus1_Sel=01, ALU_Sel=000, Bus2_Sel=00, A_Load=1, CCR_Load=1
//      -> A=80, NZVC=1010.
//   4. A=05, B=05, SUB with CCR_Load=1 -> A=00, NZVC=0100.
//      A=00, B=01, SUB -> A=FF, NZVC=1001.
//   5. PC=FF, PC_Inc=1 -> PC=00.
//      PC_Inc=1 and PC_Load=1 with Bus2=8'h20 -> PC=20.
//   6. Bus1_Sel=00, Bus2_Sel=01, MAR_Load=1 with PC=0A
//      -> address=0A.
//      Then Bus1_Sel=10 with B=3C -> to_memory=3C in the same cycle.

Source files
------------

// File: rtl/data_path_pkg.sv
// data_path_pkg: shared ALU/bus select encodings and CCR bit positions for the datapath
package data_path_pkg;

    localparam int CCR_W = 4;
    localparam int CCR_N = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_V = 1;
    localparam int CCR_C = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_INC = 3'b100,
        ALU_DEC = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        BUS1_PC   = 2'b00,
        BUS1_A    = 2'b01,
        BUS1_B    = 2'b10,
        BUS1_ZERO = 2'b11
    } bus1_sel_e;

    typedef enum logic [1:0] {
        BUS2_ALU  = 2'b00,
        BUS2_BUS1 = 2'b01,
        BUS2_MEM  = 2'b10,
        BUS2_ZERO = 2'b11
    } bus2_sel_e;

    function automatic logic is_arith(input alu_op_e op);
        return op == ALU_ADD || op == ALU_SUB || op == ALU_INC || op == ALU_DEC;
    endfunction

endpackage

// File: rtl/data_path_alu_8bit.sv
// alu_8bit: combinational ALU, X from Bus1 and Y from the B register, producing result and NZVC
module alu_8bit
    import data_path_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
    input  logic [2:0]       ALU_Sel,
    output logic [W-1:0]     Result,
    output logic [CCR_W-1:0] NZVC
);

    alu_op_e      op;
    logic [W-1:0] y_op;
    logic         sub;
    logic [W:0]   ext;
    logic         v_add;
    logic         v_sub;

    // INC/DEC reuse the adder with a constant 1; bit W of the extended result is carry or borrow
    always_comb begin
        op     = alu_op_e'(ALU_Sel);
        y_op   = (op == ALU_INC || op == ALU_DEC) ? W'(1) : Y;
        sub    = op == ALU_SUB || op == ALU_DEC;
        ext    = sub ? {1'b0, X} - {1'b0, y_op} : {1'b0, X} + {1'b0, y_op};
        v_add  = (X[W-1] == y_op[W-1]) && (ext[W-1] != X[W-1]);
        v_sub  = (X[W-1] != y_op[W-1]) && (ext[W-1] != X[W-1]);
        Result = is_arith(op) ? ext[W-1:0] :
                 op == ALU_AND ? X & Y :
                 op == ALU_OR  ? X | Y :
                 op == ALU_XOR ? X ^ Y : ~X;
        NZVC        = '0;
        NZVC[CCR_N] = Result[W-1];
        NZVC[CCR_Z] = Result == '0;
        NZVC[CCR_V] = is_arith(op) && (sub ? v_sub : v_add);
        NZVC[CCR_C] = is_arith(op) && ext[W];
    end

endmodule

// File: rtl/data_path.sv
// data_path: CPU datapath with IR/MAR/PC/A/B/CCR, two internal buses, ALU and memory interface
module data_path
    import data_path_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] PC_RST = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              PC_Inc,
    input  logic              A_Load,
    input  logic              B_Load,
    input  logic              CCR_Load,
    input  logic [2:0]        ALU_Sel,
    input  logic [1:0]        Bus1_Sel,
    input  logic [1:0]        Bus2_Sel,
    input  logic [DATA_W-1:0] from_memory,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic [DATA_W-1:0] IR,
    output logic [CCR_W-1:0]  CCR_Result
);

    logic [DATA_W-1:0] ir_q, ir_d, mar_q, mar_d, pc_q, pc_d, a_q, a_d, b_q, b_d;
    logic [CCR_W-1:0]  ccr_q, ccr_d;
    logic [DATA_W-1:0] bus1, bus2, alu_result;
    logic [CCR_W-1:0]  alu_nzvc;

    alu_8bit #(.W(DATA_W)) u_alu (
        .X       (bus1),
        .Y       (b_q),
        .ALU_Sel (ALU_Sel),
        .Result  (alu_result),
        .NZVC    (alu_nzvc)
    );

    // Bus muxes: Bus1 feeds the ALU and memory write data, Bus2 feeds every register load
    always_comb begin
        bus1 = bus1_sel_e'(Bus1_Sel) == BUS1_PC ? pc_q :
               bus1_sel_e'(Bus1_Sel) == BUS1_A  ? a_q  :
               bus1_sel_e'(Bus1_Sel) == BUS1_B  ? b_q  : '0;
        bus2 = bus2_sel_e'(Bus2_Sel) == BUS2_ALU  ? alu_result :
               bus2_sel_e'(Bus2_Sel) == BUS2_BUS1 ? bus1       :
               bus2_sel_e'(Bus2_Sel) == BUS2_MEM  ? from_memory : '0;
    end

    // Next-state: each register holds unless loaded; PC_Load wins over PC_Inc
    always_comb begin
        ir_d  = IR_Load  ? bus2 : ir_q;
        mar_d = MAR_Load ? bus2 : mar_q;
        a_d   = A_Load   ? bus2 : a_q;
        b_d   = B_Load   ? bus2 : b_q;
        pc_d  = PC_Load  ? bus2 : PC_Inc ? pc_q + DATA_W'(1) : pc_q;
        ccr_d = CCR_Load ? alu_nzvc : ccr_q;
    end

    // Register bank with synchronous active-low reset overriding all loads
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ir_q  <= '0;
            mar_q <= '0;
            pc_q  <= PC_RST;
            a_q   <= '0;
            b_q   <= '0;
            ccr_q <= '0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            pc_q  <= pc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ccr_q <= ccr_d;
        end
    end

    assign address    = mar_q;
    assign to_memory  = bus1;
    assign IR         = ir_q;
    assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed and random stimulus for data_path checked against a behavioural model
module tb_data_path;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, IR;
    logic [3:0] CCR_Result;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_ir, m_mar, m_pc, m_a, m_b;
    logic [3:0] m_ccr;

    data_path dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IR_Load     (IR_Load),
        .MAR_Load    (MAR_Load),
        .PC_Load     (PC_Load),
        .PC_Inc      (PC_Inc),
        .A_Load      (A_Load),
        .B_Load      (B_Load),
        .CCR_Load    (CCR_Load),
        .ALU_Sel     (ALU_Sel),
        .Bus1_Sel    (Bus1_Sel),
        .Bus2_Sel    (Bus2_Sel),
        .from_memory (from_memory),
        .address     (address),
        .to_memory   (to_memory),
        .IR          (IR),
        .CCR_Result  (CCR_Result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU from integer arithmetic: flags from signed range and unsigned bounds
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        int ux, uy, sx, sy, r, s;
        logic c, v;
        logic [7:0] res;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        c = 1'b0; s = 0;
        case (op)
            3'd0: begin r = ux + uy; s = sx + sy; c = r > 255; end
            3'd1: begin r = ux - uy; s = sx - sy; c = ux < uy; end
            3'd2: r = ux & uy;
            3'd3: r = ux | uy;
            3'd4: begin r = ux + 1; s = sx + 1; c = r > 255; end
            3'd5: begin r = ux - 1; s = sx - 1; c = ux == 0; end
            3'd6: r = ux ^ uy;
            default: r = ~ux;
        endcase
        v = s > 127 || s < -128;
        res = r[7:0];
        return {res[7], res == 8'h00, v, c, res};
    endfunction

    function automatic logic [7:0] bus1_ref();
        case (Bus1_Sel)
            2'd0: return m_pc;
            2'd1: return m_a;
            2'd2: return m_b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic idle();
        Reset = 1'b1;
        {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = '0;
        ALU_Sel = 3'd0;
        Bus1_Sel = 2'd0;
        Bus2_Sel = 2'd0;
    endtask

    // One clock: check Bus1 on to_memory, advance the model at the edge, check registers after it
    task automatic tick(input bit chk_comb);
        logic [7:0] b1, b2;
        logic [11:0] ar;
        #1;
        b1 = bus1_ref();
        ar = alu_ref(ALU_Sel, b1, m_b);
        b2 = Bus2_Sel == 2'd0 ? ar[7:0] : Bus2_Sel == 2'd1 ? b1 : Bus2_Sel == 2'd2 ? from_memory : 8'h00;
        if (chk_comb) check("to_memory", {24'd0, to_memory}, {24'd0, b1});
        @(posedge Clk);
        if (!Reset) begin
            {m_ir, m_mar, m_a, m_b, m_ccr} = '0;
            m_pc = 8'h00;
        end else begin
            if (IR_Load) m_ir = b2;
            if (MAR_Load) m_mar = b2;
            if (A_Load) m_a = b2;
            if (B_Load) m_b = b2;
            if (PC_Load) m_pc = b2;
            else if (PC_Inc) m_pc = m_pc + 8'd1;
            if (CCR_Load) m_ccr = ar[11:8];
        end
        @(negedge Clk);
        check("IR", {24'd0, IR}, {24'd0, m_ir});
        check("address", {24'd0, address}, {24'd0, m_mar});
        check("CCR", {28'd0, CCR_Result}, {28'd0, m_ccr});
    endtask

    // Read a register onto to_memory in the current cycle (at most three per cycle)
    task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string tag);
        Bus1_Sel = sel;
        #1;
        check(tag, {24'd0, to_memory}, {24'd0, exp});
    endtask

    // Load A (0), B (1) or PC (2) from memory data through Bus2
    task automatic ld(input int r, input logic [7:0] v);
        idle();
        from_memory = v;
        Bus2_Sel = 2'd2;
        A_Load = r == 0;
        B_Load = r == 1;
        PC_Load = r == 2;
        tick(1);
        idle();
    endtask

    task automatic alu_op(input logic [2:0] op);
        idle();
        Bus1_Sel = 2'd1;
        ALU_Sel = op;
        A_Load = 1'b1;
        CCR_Load = 1'b1;
        tick(1);
        idle();
    endtask

    initial begin
        m_ir = 0; m_mar = 0; m_pc = 0; m_a = 0; m_b = 0; m_ccr = 0;
        idle();
        from_memory = 8'h55;
        @(negedge Clk);
        Reset = 1'b0;
        {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = '1;
        Bus2_Sel = 2'd2;
        tick(0);
        check("rst_ir", {24'd0, IR}, 32'h00);
        check("rst_addr", {24'd0, address}, 32'h00);
        check("rst_ccr", {28'd0, CCR_Result}, 32'h0);
        idle();
        peek(2'd0, 8'h00, "rst_pc");
        peek(2'd1, 8'h00, "rst_a");
        peek(2'd2, 8'h00, "rst_b");
        idle();
        from_memory = 8'h86;
        Bus2_Sel = 2'd2;
        IR_Load = 1'b1;
        tick(1);
        check("ir_load", {24'd0, IR}, 32'h86);
        idle();
        peek(2'd0, 8'h00, "ir_pc_hold");
        ld(0, 8'h7F);
        ld(1, 8'h01);
        alu_op(3'd0);
        check("add_ccr", {28'd0, CCR_Result}, 32'b1010);
        peek(2'd1, 8'h80, "add_a");
        ld(0, 8'h05);
        ld(1, 8'h05);
        alu_op(3'd1);
        check("sub_eq_ccr", {28'd0, CCR_Result}, 32'b0100);
        peek(2'd1, 8'h00, "sub_eq_a");
        ld(1, 8'h01);
        alu_op(3'd1);
        check("sub_brw_ccr", {28'd0, CCR_Result}, 32'b1001);
        peek(2'd1, 8'hFF, "sub_brw_a");
        ld(2, 8'hFF);
        PC_Inc = 1'b1;
        tick(1);
        idle();
        peek(2'd0, 8'h00, "pc_wrap");
        from_memory = 8'h20;
        Bus2_Sel = 2'd2;
        PC_Inc = 1'b1;
        PC_Load = 1'b1;
        tick(1);
        idle();
        peek(2'd0, 8'h20, "pc_prio");
        ld(2, 8'h0A);
        Bus1_Sel = 2'd0;
        Bus2_Sel = 2'd1;
        MAR_Load = 1'b1;
        tick(1);
        check("mar_pc", {24'd0, address}, 32'h0A);
        ld(1, 8'h3C);
        peek(2'd2, 8'h3C, "tomem_b");
        for (int i = 0; i < 400; i++) begin
            Reset = $urandom_range(0, 24) != 0;
            {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load} = 7'($urandom);
            ALU_Sel = 3'($urandom);
            Bus1_Sel = 2'($urandom);
            Bus2_Sel = 2'($urandom);
            from_memory = 8'($urandom);
            tick(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
